// File: rtl/nbit_sr_arb_if.sv
// Bus bundle between the requesters/delay line and the nbit_sr_arb arbiter.
// Handshake: requester i transfers its vector in a cycle where
// req_vld[i] & req_rdy[i] are both high at the rising clock edge; req_rdy is
// one-hot or zero and may depend combinationally on req_vld, so a requester
// must never wait for req_rdy before raising req_vld. rsp_vld carries no
// back-pressure: a response is delivered in exactly the cycle it is shown.
interface nbit_sr_arb_if #(
    parameter int DSIZE = 1,
    parameter int VEC   = 10,
    parameter int NREQ  = 4
);
    localparam int W = VEC * DSIZE;

    logic [NREQ-1:0]   req_vld;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_rdy;
    logic [W-1:0]      sr_din;
    logic [W-1:0]      sr_dout;
    logic [NREQ-1:0]   rsp_vld;
    logic [W-1:0]      rsp_data;
    logic              drain_req;
    logic              drain_done;
    logic              busy;

    // Requester / delay-line side
    modport master (
        output req_vld, req_data, sr_dout, drain_req,
        input  req_rdy, sr_din, rsp_vld, rsp_data, drain_done, busy
    );

    // Arbiter side
    modport slave (
        input  req_vld, req_data, sr_dout, drain_req,
        output req_rdy, sr_din, rsp_vld, rsp_data, drain_done, busy
    );
endinterface

// File: rtl/nbit_sr_arb.sv
// nbit_sr_arb: round-robin arbiter sharing one external DLY-deep multi-lane
// delay line among NREQ requesters. A tag pipeline of the same depth follows
// each vector so its exit is steered back to the owner. Per-requester
// outstanding limit (MAX_OUT) and a RUN/DRAIN/HALT sequence for orderly stop.
// Optional macro NBIT_SR_ARB_STATS_EN adds saturating grant_cnt/block_cnt.
module nbit_sr_arb #(
    parameter int DSIZE   = 1,
    parameter int VEC     = 10,
    parameter int DLY     = 1,
    parameter int NREQ    = 4,
    parameter int MAX_OUT = 2
) (
    input  logic               clk,
    input  logic               rst_b,
    nbit_sr_arb_if.slave       bus,
    output logic [1:0]         fsm_state
`ifdef NBIT_SR_ARB_STATS_EN
    ,
    output logic [31:0]        grant_cnt,
    output logic [31:0]        block_cnt
`endif
);
    localparam int W  = VEC * DSIZE;
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t            state;
    logic              drain_done_q;
    logic [IW-1:0]     ptr;
    logic [CW-1:0]     cnt [NREQ];
    logic [DLY-1:0]    tag_vld;
    logic [IW-1:0]     tag_idx [DLY];

    logic [NREQ-1:0]   rsp_vld_w;
    logic              busy_w;
    logic [NREQ-1:0]   elig;
    logic              grant_found;
    logic [IW-1:0]     grant_idx;
    logic [NREQ-1:0]   req_rdy_w;
    logic [W-1:0]      sr_din_w;
    logic [IW-1:0]     next_ptr;

    // Decode the last tag stage into the one-hot response strobe
    always_comb begin
        rsp_vld_w = '0;
        if (tag_vld[DLY-1]) rsp_vld_w[tag_idx[DLY-1]] = 1'b1;
    end

    assign busy_w = |tag_vld;

    // Eligibility; a response leaving this cycle frees its slot for a grant in the same cycle
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = bus.req_vld[i] && rst_b && (state == ST_RUN) &&
                      ((cnt[i] < CW'(MAX_OUT)) || rsp_vld_w[i]);
        end
    end

    // Round-robin search starting at ptr, wrapping NREQ-1 -> 0
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!grant_found && elig[idx[IW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = idx[IW-1:0];
            end
        end
    end

    // One-hot grant and the granted vector (zero bubble when idle)
    always_comb begin
        req_rdy_w = '0;
        sr_din_w  = '0;
        if (grant_found) begin
            req_rdy_w[grant_idx] = 1'b1;
            sr_din_w             = bus.req_data[grant_idx*W +: W];
        end
    end

    assign next_ptr = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);

    assign bus.req_rdy    = req_rdy_w;
    assign bus.sr_din     = sr_din_w;
    assign bus.rsp_vld    = rsp_vld_w;
    assign bus.rsp_data   = bus.sr_dout;
    assign bus.busy       = busy_w;
    assign bus.drain_done = drain_done_q;
    assign fsm_state      = state;

    // RUN/DRAIN/HALT sequencing; drain_done is registered alongside the state
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state        <= ST_RUN;
            drain_done_q <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (bus.drain_req) state <= ST_DRAIN;
                    drain_done_q <= 1'b0;
                end
                ST_DRAIN: begin
                    if (!bus.drain_req) begin
                        state        <= ST_RUN;
                        drain_done_q <= 1'b0;
                    end else if (!busy_w) begin
                        state        <= ST_HALT;
                        drain_done_q <= 1'b1;
                    end else begin
                        drain_done_q <= 1'b0;
                    end
                end
                ST_HALT: begin
                    if (!bus.drain_req) begin
                        state        <= ST_RUN;
                        drain_done_q <= 1'b0;
                    end else begin
                        drain_done_q <= 1'b1;
                    end
                end
                default: begin
                    state        <= ST_RUN;
                    drain_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Round-robin pointer advances past the winner, holds on idle cycles
    always_ff @(posedge clk) begin
        if (!rst_b) ptr <= '0;
        else if (grant_found) ptr <= next_ptr;
    end

    // Outstanding counters: +1 on grant, -1 on response, both = unchanged
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (!rst_b) begin
                cnt[i] <= '0;
            end else if (req_rdy_w[i] && !rsp_vld_w[i]) begin
                cnt[i] <= cnt[i] + CW'(1);
            end else if (!req_rdy_w[i] && rsp_vld_w[i]) begin
                cnt[i] <= cnt[i] - CW'(1);
            end
        end
    end

    // Tag pipeline mirroring the external delay line depth
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            tag_vld <= '0;
            for (int k = 0; k < DLY; k++) tag_idx[k] <= '0;
        end else begin
            tag_vld[0] <= grant_found;
            tag_idx[0] <= grant_idx;
            for (int k = 1; k < DLY; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_idx[k] <= tag_idx[k-1];
            end
        end
    end

`ifdef NBIT_SR_ARB_STATS_EN
    logic blocked;

    // A cycle is blocked when some valid requester sits at its limit
    always_comb begin
        blocked = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_vld[i] && (cnt[i] == CW'(MAX_OUT))) blocked = 1'b1;
        end
    end

    // Saturating grant and blocked-cycle statistics
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            grant_cnt <= '0;
            block_cnt <= '0;
        end else begin
            if (grant_found && (grant_cnt != 32'hFFFF_FFFF)) grant_cnt <= grant_cnt + 32'd1;
            if (blocked && (block_cnt != 32'hFFFF_FFFF)) block_cnt <= block_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nbit_sr_arb.sv
// Bench for nbit_sr_arb (NREQ=4, DLY=3, VEC=2, DSIZE=8, MAX_OUT=2) with an
// external 3-stage register chain as the delay line. Hand-written vector
// table for the directed scenarios, then randomized traffic compared every
// cycle against a queue-based reference model.
module tb_nbit_sr_arb;
    localparam int DSIZE   = 8;
    localparam int VEC     = 2;
    localparam int DLY     = 3;
    localparam int NREQ    = 4;
    localparam int MAX_OUT = 2;
    localparam int W       = VEC * DSIZE;
    localparam logic [NREQ*W-1:0] TBL_DATA = 64'h0303_0202_0101_0000;

    logic        clk;
    logic        rst_b;
    logic [1:0]  fsm_state;
`ifdef NBIT_SR_ARB_STATS_EN
    logic [31:0] grant_cnt;
    logic [31:0] block_cnt;
`endif

    nbit_sr_arb_if #(.DSIZE(DSIZE), .VEC(VEC), .NREQ(NREQ)) bus ();

    nbit_sr_arb #(
        .DSIZE(DSIZE), .VEC(VEC), .DLY(DLY), .NREQ(NREQ), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .bus       (bus),
        .fsm_state (fsm_state)
`ifdef NBIT_SR_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt),
        .block_cnt (block_cnt)
`endif
    );

    // ---------------- clock / reset / external delay line ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [W-1:0] dl [DLY];
    always @(posedge clk) begin
        dl[0] <= bus.sr_din;
        for (int k = 1; k < DLY; k++) dl[k] <= dl[k-1];
    end
    assign bus.sr_dout = dl[DLY-1];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / reference model ----------------
    typedef struct {
        int           due;
        int           idx;
        logic [W-1:0] data;
    } flight_t;

    flight_t exp_q[$];
    int      m_ptr;
    int      m_cnt [NREQ];
    int      m_mode;        // 0 run, 1 drain, 2 halt
    int      m_grants;
    int      m_blocks;
    int      cyc;
    bit      model_on;
    int      n_checks;
    int      n_pass;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return 0;
    endfunction

    // ---------------- driver: one clock cycle with model compare ----------------
    task automatic run_cycle(input bit rst, input logic [NREQ-1:0] vld,
                             input logic [NREQ*W-1:0] data, input bit drain);
        int              rsp_idx;
        int              g;
        bit              m_busy;
        bit              blocked;
        logic [NREQ-1:0] e_rdy;
        logic [NREQ-1:0] e_rsp;
        logic [W-1:0]    e_din;
        flight_t         f;
        @(negedge clk);
        rst_b         = rst;
        bus.req_vld   = vld;
        bus.req_data  = data;
        bus.drain_req = drain;
        #1;
        rsp_idx = -1;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) rsp_idx = exp_q[0].idx;
        m_busy = (exp_q.size() > 0);
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (g < 0 && rst && m_mode == 0 && vld[i] &&
                (m_cnt[i] < MAX_OUT || rsp_idx == i)) g = i;
        end
        e_rdy = '0;
        e_din = '0;
        if (g >= 0) begin
            e_rdy[g] = 1'b1;
            e_din    = data[g*W +: W];
        end
        e_rsp = '0;
        if (rsp_idx >= 0) e_rsp[rsp_idx] = 1'b1;
        if (model_on) begin
            check("m_req_rdy", 64'(bus.req_rdy), 64'(e_rdy));
            check("m_sr_din", 64'(bus.sr_din), 64'(e_din));
            check("m_rsp_vld", 64'(bus.rsp_vld), 64'(e_rsp));
            if (rsp_idx >= 0) check("m_rsp_data", 64'(bus.rsp_data), 64'(exp_q[0].data));
            check("m_busy", 64'(bus.busy), 64'(m_busy));
            check("m_drain_done", 64'(bus.drain_done), 64'(m_mode == 2));
        end
        // advance the model across the clock edge
        if (!rst) begin
            exp_q.delete();
            m_ptr    = 0;
            m_mode   = 0;
            m_grants = 0;
            m_blocks = 0;
            for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        end else begin
            blocked = 1'b0;
            for (int i = 0; i < NREQ; i++) if (vld[i] && m_cnt[i] == MAX_OUT) blocked = 1'b1;
            if (blocked) m_blocks++;
            if (rsp_idx >= 0) begin
                m_cnt[rsp_idx]--;
                void'(exp_q.pop_front());
            end
            if (g >= 0) begin
                m_cnt[g]++;
                f.due  = cyc + DLY;
                f.idx  = g;
                f.data = data[g*W +: W];
                exp_q.push_back(f);
                m_ptr = (g + 1) % NREQ;
                m_grants++;
            end
            case (m_mode)
                0: if (drain) m_mode = 1;
                1: if (!drain) m_mode = 0; else if (!m_busy) m_mode = 2;
                default: if (!drain) m_mode = 0;
            endcase
        end
        cyc++;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit              chk;
        bit              rst;
        logic [NREQ-1:0] vld;
        bit              drain;
        logic [NREQ-1:0] rdy;
        logic [NREQ-1:0] rsp;
        bit              busy;
        bit              done;
    } vec_t;

    vec_t tbl[$];

    task automatic add_row(input bit chk, input bit rst, input logic [NREQ-1:0] vld, input bit drain,
                           input logic [NREQ-1:0] rdy, input logic [NREQ-1:0] rsp,
                           input bit busy, input bit done);
        vec_t v;
        v.chk = chk; v.rst = rst; v.vld = vld; v.drain = drain;
        v.rdy = rdy; v.rsp = rsp; v.busy = busy; v.done = done;
        tbl.push_back(v);
    endtask

    // second row shows req_rdy gated while reset is asserted with requests pending
    task automatic add_reset_pair();
        add_row(0, 0, 4'h0, 0, 4'h0, 4'h0, 0, 0);
        add_row(1, 0, 4'hF, 0, 4'h0, 4'h0, 0, 0);
    endtask

    initial begin
        bit drain_ph;
        logic [NREQ-1:0]   r_vld;
        logic [NREQ*W-1:0] r_data;
        bit                r_rst;

        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        model_on = 0;
        m_ptr    = 0;
        m_mode   = 0;
        m_grants = 0;
        m_blocks = 0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        rst_b         = 1'b0;
        bus.req_vld   = '0;
        bus.req_data  = '0;
        bus.drain_req = 1'b0;

        // power-up reset, model not yet synchronized
        run_cycle(0, '0, '0, 0);
        run_cycle(0, '0, '0, 0);
        model_on = 1;

        // A: all four requesting, round robin and pointer wrap
        add_reset_pair();
        add_row(1, 1, 4'hF, 0, 4'h1, 4'h0, 0, 0);
        add_row(1, 1, 4'hF, 0, 4'h2, 4'h0, 1, 0);
        add_row(1, 1, 4'hF, 0, 4'h4, 4'h0, 1, 0);
        add_row(1, 1, 4'hF, 0, 4'h8, 4'h1, 1, 0);
        add_row(1, 1, 4'hF, 0, 4'h1, 4'h2, 1, 0);
        add_row(1, 1, 4'hF, 0, 4'h2, 4'h4, 1, 0);
        add_row(1, 1, 4'hF, 0, 4'h4, 4'h8, 1, 0);
        add_row(1, 1, 4'hF, 0, 4'h8, 4'h1, 1, 0);
        // B: lone requester hits its outstanding limit, 2 grants per 3 cycles
        add_reset_pair();
        add_row(1, 1, 4'h4, 0, 4'h4, 4'h0, 0, 0);
        add_row(1, 1, 4'h4, 0, 4'h4, 4'h0, 1, 0);
        add_row(1, 1, 4'h4, 0, 4'h0, 4'h0, 1, 0);
        add_row(1, 1, 4'h4, 0, 4'h4, 4'h4, 1, 0);
        add_row(1, 1, 4'h4, 0, 4'h4, 4'h4, 1, 0);
        add_row(1, 1, 4'h4, 0, 4'h0, 4'h0, 1, 0);
        add_row(1, 1, 4'h4, 0, 4'h4, 4'h4, 1, 0);
        add_row(1, 1, 4'h4, 0, 4'h4, 4'h4, 1, 0);
        // C: drain to halt and resume
        add_reset_pair();
        add_row(1, 1, 4'h2, 0, 4'h2, 4'h0, 0, 0);
        add_row(1, 1, 4'h0, 1, 4'h0, 4'h0, 1, 0);
        add_row(1, 1, 4'h2, 1, 4'h0, 4'h0, 1, 0);
        add_row(1, 1, 4'h2, 1, 4'h0, 4'h2, 1, 0);
        add_row(1, 1, 4'h2, 1, 4'h0, 4'h0, 0, 0);
        add_row(1, 1, 4'h2, 1, 4'h0, 4'h0, 0, 1);
        add_row(1, 1, 4'h2, 0, 4'h0, 4'h0, 0, 1);
        add_row(1, 1, 4'h2, 0, 4'h2, 4'h0, 0, 0);
        // D: pointer at 1 with requesters 0 and 3 -> 3 first, then 0
        add_reset_pair();
        add_row(1, 1, 4'h1, 0, 4'h1, 4'h0, 0, 0);
        add_row(1, 1, 4'h9, 0, 4'h8, 4'h0, 1, 0);
        add_row(1, 1, 4'h9, 0, 4'h1, 4'h0, 1, 0);
        add_row(1, 1, 4'h0, 0, 4'h0, 4'h1, 1, 0);
        add_row(1, 1, 4'h0, 0, 4'h0, 4'h8, 1, 0);
        add_row(1, 1, 4'h0, 0, 4'h0, 4'h1, 1, 0);
        add_row(1, 1, 4'h0, 0, 4'h0, 4'h0, 0, 0);
        // E: reset with 3 in flight; stale delay-line data must stay silent
        add_reset_pair();
        add_row(1, 1, 4'hF, 0, 4'h1, 4'h0, 0, 0);
        add_row(1, 1, 4'hF, 0, 4'h2, 4'h0, 1, 0);
        add_row(1, 1, 4'hF, 0, 4'h4, 4'h0, 1, 0);
        add_row(1, 0, 4'hF, 0, 4'h0, 4'h1, 1, 0);
        add_row(1, 1, 4'h0, 0, 4'h0, 4'h0, 0, 0);
        add_row(1, 1, 4'h0, 0, 4'h0, 4'h0, 0, 0);
        add_row(1, 1, 4'h0, 0, 4'h0, 4'h0, 0, 0);
        add_row(1, 1, 4'h1, 0, 4'h1, 4'h0, 0, 0);
        add_row(1, 1, 4'h1, 0, 4'h1, 4'h0, 1, 0);
        add_row(1, 1, 4'h1, 0, 4'h0, 4'h0, 1, 0);

        for (int r = 0; r < tbl.size(); r++) begin
            run_cycle(tbl[r].rst, tbl[r].vld, TBL_DATA, tbl[r].drain);
            if (tbl[r].chk) begin
                check("t_req_rdy", 64'(bus.req_rdy), 64'(tbl[r].rdy));
                check("t_sr_din", 64'(bus.sr_din),
                      (tbl[r].rdy != 0) ? 64'(oh_idx(tbl[r].rdy) * 16'h0101) : 64'h0);
                check("t_rsp_vld", 64'(bus.rsp_vld), 64'(tbl[r].rsp));
                if (tbl[r].rsp != 0)
                    check("t_rsp_data", 64'(bus.rsp_data), 64'(oh_idx(tbl[r].rsp) * 16'h0101));
                check("t_busy", 64'(bus.busy), 64'(tbl[r].busy));
                check("t_drain_done", 64'(bus.drain_done), 64'(tbl[r].done));
            end
        end

        // randomized traffic with occasional drain phases and resets
        drain_ph = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) drain_ph = ~drain_ph;
            r_rst  = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
            r_vld  = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            r_data = {$urandom, $urandom};
            run_cycle(r_rst, r_vld, r_data, drain_ph);
        end

`ifdef NBIT_SR_ARB_STATS_EN
        // statistics after the random run and after a clean directed burst
        check("s_grant_cnt", 64'(grant_cnt), 64'(m_grants));
        check("s_block_cnt", 64'(block_cnt), 64'(m_blocks));
        run_cycle(0, '0, TBL_DATA, 0);
        check("s_grant_rst", 64'(grant_cnt), 64'd0);
        check("s_block_rst", 64'(block_cnt), 64'd0);
        for (int c = 0; c < 10; c++) run_cycle(1, 4'h4, TBL_DATA, 0);
        run_cycle(1, '0, TBL_DATA, 0);
        check("s_grant_dir", 64'(grant_cnt), 64'(m_grants));
        check("s_block_dir", 64'(block_cnt), 64'(m_blocks));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
